// File: rtl/header_loader.sv
// header_loader: packs host bytes big-endian into 32-bit header words and queues them in a 2-entry FIFO.
// Optional macro LOADER_SYNC_EN adds a 2-flop strobe synchronizer with rising-edge detection.
module header_loader #(
  parameter int HDR_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  input  logic        clr,
  output logic [31:0] word_out,
  output logic [4:0]  word_idx,
  output logic        word_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        ovf
);
  localparam logic [4:0] IDX_LAST = 5'(HDR_WORDS - 1);

  logic        stb;
  logic [1:0]  cnt_q;
  logic [23:0] acc_q;
  logic [4:0]  idx_q, idx_d;
  logic        ovf_q;
  logic [36:0] mem_q [2];
  logic        rd_q, wr_q;
  logic [1:0]  fill_q, fill_d;
  logic        push_req, pop, push, drop;

`ifdef LOADER_SYNC_EN
  logic [2:0] sync_q;
  // Two synchronizer stages plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[1:0], byte_stb};
  assign stb = sync_q[1] & ~sync_q[2];
`else
  assign stb = byte_stb;
`endif

  assign push_req = stb && (cnt_q == 2'd3);
  assign pop      = word_valid && word_ready;
  assign push     = push_req && (fill_q != 2'd2 || pop);
  assign drop     = push_req && fill_q == 2'd2 && !pop;

  // Next FIFO occupancy and word index; the index only moves when a word is actually queued.
  always_comb begin
    fill_d = fill_q + {1'b0, push} - {1'b0, pop};
    idx_d  = push ? (idx_q == IDX_LAST ? 5'd0 : idx_q + 5'd1) : idx_q;
  end

  // Byte packing, FIFO storage and sticky overflow; clr outranks any same-cycle byte.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
      mem_q  <= '{default: '0};
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      fill_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      fill_q <= '0;
    end else begin
      if (stb) begin
        cnt_q <= cnt_q + 2'd1;
        acc_q <= {acc_q[15:0], byte_in};
      end
      if (push) begin
        mem_q[wr_q] <= {idx_q, acc_q, byte_in};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (drop) ovf_q <= 1'b1;
      fill_q <= fill_d;
      idx_q  <= idx_d;
    end

  assign {word_idx, word_out} = mem_q[rd_q];
  assign word_last  = word_idx == IDX_LAST;
  assign word_valid = fill_q != 2'd0;
  assign busy       = cnt_q != 2'd0 || fill_q != 2'd0;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_header_loader.sv
// tb_header_loader: directed stimulus with a queue-based reference model and literal spot checks.
module tb_header_loader;
  localparam int HDR_WORDS = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in = '0;
  logic        byte_stb = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] word_out;
  logic [4:0]  word_idx;
  logic        word_last, word_valid, busy, ovf;
  logic        word_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int lasts = 0;

  logic [7:0]  mb[$];
  logic [36:0] mq[$];
  int          m_idx = 0;
  bit          m_ovf = 1'b0;

  header_loader #(.HDR_WORDS(HDR_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_stb(byte_stb), .clr(clr),
    .word_out(word_out), .word_idx(word_idx), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: a byte list that becomes a word every 4 bytes, and a FIFO of at most 2 words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      mb.delete();
      mq.delete();
      m_idx = 0;
      m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && word_ready) mq.delete(0);
      if (byte_stb) begin
        mb.push_back(byte_in);
        if (mb.size() == 4) begin
          if (mq.size() < 2) begin
            mq.push_back({5'(m_idx), mb[0], mb[1], mb[2], mb[3]});
            m_idx = (m_idx + 1) % HDR_WORDS;
          end else m_ovf = 1'b1;
          mb.delete();
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("valid", 64'(word_valid), 64'(mq.size() != 0));
    chk("busy", 64'(busy), 64'(mb.size() != 0 || mq.size() != 0));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("data", 64'(word_out), 64'(mq[0][31:0]));
      chk("idx", 64'(word_idx), 64'(mq[0][36:32]));
      chk("last", 64'(word_last), 64'(mq[0][36:32] == 5'(HDR_WORDS - 1)));
    end else if (!rst_n) begin
      chk("rst_data", 64'(word_out), 64'd0);
      chk("rst_idx", 64'(word_idx), 64'd0);
      chk("rst_last", 64'(word_last), 64'd0);
    end
  end

  always @(negedge clk)
    if (word_valid && word_ready) begin
      pops++;
      if (word_last) lasts++;
    end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_stb = 1'b1;
    @(negedge clk);
    byte_stb = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic chk_word(input string nm, input logic [31:0] w, input logic [4:0] i, input logic l);
    chk({nm, "_valid"}, 64'(word_valid), 64'd1);
    chk({nm, "_data"}, 64'(word_out), 64'(w));
    chk({nm, "_idx"}, 64'(word_idx), 64'(i));
    chk({nm, "_last"}, 64'(word_last), 64'(l));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 64'(word_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();
    // Single word with ready high: visible for exactly one cycle.
    word_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk_word("w0", 32'h01020304, 5'd0, 1'b0);
    tick();
    chk("w0_gone", 64'(word_valid), 64'd0);
    // Full 80-byte header, then the index wraps.
    do_clr();
    pops = 0;
    lasts = 0;
    for (int i = 0; i < 80; i++) send(8'(i));
    chk_word("hdr19", 32'h4C4D4E4F, 5'd19, 1'b1);
    tick();
    chk("hdr_pops", 64'(pops), 64'd20);
    chk("hdr_lasts", 64'(lasts), 64'd1);
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i));
    chk_word("wrap", 32'hA0A1A2A3, 5'd0, 1'b0);
    tick();
    // Backpressure: two words held, third dropped, ovf sticky.
    do_clr();
    word_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i));
    chk("ovf_set", 64'(ovf), 64'd1);
    chk_word("hold0", 32'h10111213, 5'd0, 1'b0);
    tick();
    tick();
    chk_word("hold1", 32'h10111213, 5'd0, 1'b0);
    word_ready = 1'b1;
    tick();
    chk_word("pop1", 32'h14151617, 5'd1, 1'b0);
    tick();
    chk("drained", 64'(word_valid), 64'd0);
    for (int i = 0; i < 4; i++) send(8'(8'h1C + i));
    chk_word("after_drop", 32'h1C1D1E1F, 5'd2, 1'b0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    tick();
    // Full FIFO with push and pop in the same cycle.
    do_clr();
    word_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'(8'h20 + i));
    word_ready = 1'b1;
    send(8'h2B);
    word_ready = 1'b0;
    chk("pp_ovf", 64'(ovf), 64'd0);
    chk_word("pp_head", 32'h24252627, 5'd1, 1'b0);
    word_ready = 1'b1;
    tick();
    chk_word("pp_tail", 32'h28292A2B, 5'd2, 1'b0);
    tick();
    chk("pp_empty", 64'(word_valid), 64'd0);
    // clr beats a same-cycle byte.
    send(8'h30);
    send(8'h31);
    clr = 1'b1;
    byte_stb = 1'b1;
    byte_in = 8'h32;
    tick();
    clr = 1'b0;
    byte_stb = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
    chk_word("post_clr", 32'h40414243, 5'd0, 1'b0);
    tick();
    // Asynchronous reset mid-word.
    send(8'h50);
    send(8'h51);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(word_valid), 64'd0);
    chk("arst_data", 64'(word_out), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i));
    chk_word("post_rst", 32'h60616263, 5'd0, 1'b0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
